// File: rtl/regfile_write_buffer_pkg.sv
// rtl/regfile_write_buffer_pkg.sv - shared register-file constants and bypass types
package regfile_write_buffer_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam int WB_DEPTH = 4;

    typedef enum logic [1:0] {
        BYP_NONE = 2'd0,
        BYP_OUT  = 2'd1,
        BYP_FIFO = 2'd2
    } byp_src_e;

endpackage

// File: rtl/regfile_write_buffer_if.sv
// rtl/regfile_write_buffer_if.sv - write-request, regfile-write and bypass signal bundle
interface regfile_write_buffer_if
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          wr_stall;
    logic          wr_enable;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output in_valid, in_addr, in_data, wr_stall, rd_addr,
        input  in_ready, wr_enable, wr_addr, wr_data, rd_hit, rd_data, count, full, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, wr_stall, rd_addr,
        output in_ready, wr_enable, wr_addr, wr_data, rd_hit, rd_data, count, full, empty
    );

endinterface

// File: rtl/regfile_wb_fifo.sv
// rtl/regfile_wb_fifo.sv - circular write queue exposing every entry for the bypass search
module regfile_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic [AW-1:0]                  push_addr_i,
    input  logic [DW-1:0]                  push_data_i,
    input  logic                           pop_i,
    output logic [AW-1:0]                  head_addr_o,
    output logic [DW-1:0]                  head_data_o,
    output logic [DEPTH-1:0][AW-1:0]       entry_addr_o,
    output logic [DEPTH-1:0][DW-1:0]       entry_data_o,
    output logic [DEPTH-1:0]               entry_valid_o,
    output logic [$clog2(DEPTH)-1:0]       tail_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     full_q, empty_q;

    // Caller guarantees push only when not full and pop only when not empty,
    // so head and tail never target the same slot on one edge.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (push_i) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    assign head_addr_o   = addr_q[head_q];
    assign head_data_o   = data_q[head_q];
    assign entry_addr_o  = addr_q;
    assign entry_data_o  = data_q;
    assign entry_valid_o = valid_q;
    assign tail_o        = tail_q;
    assign count_o       = count_q;
    assign full_o        = full_q;
    assign empty_o       = empty_q;

endmodule

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - queued write-back into the regfile write port with read bypass
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     push, pop;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [DEPTH-1:0][AW-1:0] entry_addr;
    logic [DEPTH-1:0][DW-1:0] entry_data;
    logic [DEPTH-1:0]         entry_valid;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    logic                     full, empty;

    logic                     wr_enable_q, wr_enable_d;
    logic [AW-1:0]            wr_addr_q, wr_addr_d;
    logic [DW-1:0]            wr_data_q, wr_data_d;

    byp_src_e                 byp_src;
    logic [DW-1:0]            byp_data;
    logic [PW-1:0]            idx;

    // Register-0 writes complete the handshake but are dropped here.
    assign bus.in_ready = !full;
    assign push = bus.in_valid && !full && (bus.in_addr != AW'(REG_ZERO));
    assign pop  = !empty && !bus.wr_stall;

    regfile_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (push),
        .push_addr_i   (bus.in_addr),
        .push_data_i   (bus.in_data),
        .pop_i         (pop),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .entry_addr_o  (entry_addr),
        .entry_data_o  (entry_data),
        .entry_valid_o (entry_valid),
        .tail_o        (tail),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty)
    );

    always_comb begin
        wr_enable_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (pop) begin
            wr_enable_d = 1'b1;
            wr_addr_d   = head_addr;
            wr_data_d   = head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_enable_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_enable_q <= wr_enable_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Lowest priority first: output stage, then queue from oldest to youngest,
    // so the youngest matching entry is the last assignment and wins.
    always_comb begin
        byp_src  = BYP_NONE;
        byp_data = '0;
        idx      = '0;
        if (bus.rd_addr != AW'(REG_ZERO)) begin
            if (wr_enable_q && (wr_addr_q == bus.rd_addr)) begin
                byp_src  = BYP_OUT;
                byp_data = wr_data_q;
            end
            for (int k = DEPTH - 1; k >= 0; k--) begin
                idx = tail - PW'(1) - PW'(k);
                if (entry_valid[idx] && (entry_addr[idx] == bus.rd_addr)) begin
                    byp_src  = BYP_FIFO;
                    byp_data = entry_data[idx];
                end
            end
        end
    end

    assign bus.rd_hit    = (byp_src != BYP_NONE);
    assign bus.rd_data   = byp_data;
    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = empty;

endmodule
